urv_regfile_seq: RTL and testbench
==================================

// Module: urv_regfile_seq
// PURPOSE
//  Sequencer/arbiter for the register-file write and read-address ports. After reset it
//  clears x1..x31, since the block-RAM banks have no reset. It then passes pipeline
//  writeback through and shares the ports with a debug access channel.
//  It sits between the writeback stage / debug module and the register-file banks.
// PARAMETERS
//  INIT_VALUE  32'h0  value written to x1..x31 during the reset sweep
//  INIT_EN     1      1: run the sweep after reset; 0: go straight to IDLE
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   synchronous reset, active-high
//  w_rd_i         in   5   pipeline writeback destination register
//  w_rd_value_i   in   32  pipeline writeback data
//  w_rd_store_i   in   1   pipeline writeback strobe
//  pipe_rs_i      in   5   pipeline read address (rs1 bank)
//  pipe_idle_i    in   1   pipeline drained, no writeback in flight
//  stall_o        out  1   holds the decode stage (fed to d_stall)
//  dbg_req_i      in   1   debug access request; held high until dbg_ack_o
//  dbg_we_i       in   1   1 = write, 0 = read; stable while dbg_req_i is high
//  dbg_addr_i     in   5   debug register index
//  dbg_wdata_i    in   32  debug write data
//  dbg_ack_o      out  1   one-cycle completion pulse
//  dbg_rdata_o    out  32  debug read data, valid while dbg_ack_o is high and held afterwards
//  rf_waddr_o     out  5   register-file write address
//  rf_wdata_o     out  32  register-file write data
//  rf_we_o        out  1   register-file write enable; never high for address 0
//  rf_raddr_o     out  5   register-file read address (rs1 bank)
//  rf_q_i         in   32  register-file read data, sync read, 1-cycle latency
//  init_done_o    out  1   high once the sweep has completed
// BEHAVIOUR
//  Reset values:
//   - state = INIT if INIT_EN=1, else IDLE; cnt = 1.
//   - stall_o = 1 if INIT_EN=1, else 0.
//   - dbg_ack_o = 0; dbg_rdata_o = 0; rf_we_o = 0.
//   - init_done_o = 0 if INIT_EN=1, else 1.
//  A reset in any state aborts the operation in progress, with no ack, and restarts the sweep.
//  States:
//   - INIT:
//     - rf_we_o = 1, rf_waddr_o = cnt, rf_wdata_o = INIT_VALUE; cnt increments every cycle.
//     - After the cnt=31 write, go to IDLE: 31 cycles total.
//     - init_done_o rises in the first IDLE cycle and stays high until reset.
//     - stall_o = 1 throughout INIT; w_rd_store_i is ignored.
//   - IDLE:
//     - stall_o = 0; rf_raddr_o = pipe_rs_i.
//     - Writeback passes through combinationally: rf_we_o = w_rd_store_i && (w_rd_i != 0).
//     - dbg_req_i = 1 -> DRAIN.
//   - DRAIN:
//     - stall_o = 1; writeback pass-through continues so in-flight instructions retire.
//     - pipe_idle_i = 1 -> ACCESS. No timeout.
//   - ACCESS, write:
//     - If dbg_addr_i != 0: rf_we_o = 1, rf_waddr_o = dbg_addr_i, rf_wdata_o = dbg_wdata_i.
//     - A write to x0 is dropped silently.
//     - -> ACK.
//   - ACCESS, read: rf_raddr_o = dbg_addr_i -> RDWAIT.
//   - RDWAIT: dbg_rdata_o <= (dbg_addr_i == 0) ? 0 : rf_q_i -> ACK.
//   - ACK: dbg_ack_o = 1 for exactly one cycle; stall_o stays 1; -> IDLE.
//  Latency:
//   - Write: ack 2 cycles after the cycle in which pipe_idle_i is sampled high.
//   - Read: ack 3 cycles after that cycle.
//  Collisions:
//   - w_rd_store_i with w_rd_i != 0 in ACCESS (pipeline not truly idle): the pipeline write wins.
//   - The FSM stays in ACCESS and retries next cycle.
//  Back-to-back requests:
//   - dbg_req_i still high in the IDLE cycle after ACK starts a new access.
//   - The requester must drop dbg_req_i in the ACK cycle to avoid a repeat.
//  Wrap: cnt is 5 bits and cnt=31 is terminal; it never wraps to 0, so x0 is never written.
// TESTING
//  1. Reset for 2 cycles, INIT_EN=1 -> writes to addresses 1..31 with value 0, no write to 0;
//     init_done_o rises on cycle 32 after reset release; stall_o = 1 until then.
//  2. IDLE: w_rd=5, value 32'hDEADBEEF, store=1 -> same-cycle rf_we_o=1, rf_waddr_o=5.
//     Same stimulus with w_rd=0 -> rf_we_o=0.
//  3. dbg write addr=7, data 32'h12345678, pipe_idle_i low for 3 cycles:
//     -> stall_o high during DRAIN; write lands 1 cycle after pipe_idle_i rises;
//     -> single ack pulse, then stall_o drops.
//  4. dbg read addr=7 after test 3 (model rf_q_i as a 1-cycle RAM):
//     -> dbg_rdata_o = 32'h12345678 at ack. Read addr=0 -> 0.
//  5. Pipeline writeback (x9) in ACCESS with a debug write to x3:
//     -> x9 written first, x3 written the next cycle, ack one cycle later.
//  6. rst_i asserted in RDWAIT -> no ack; sweep restarts from cnt=1;
//     dbg_rdata_o = 0; init_done_o = 0.

Source files
------------

// File: rtl/urv_regfile_seq_if.sv
// rtl/urv_regfile_seq_if.sv - writeback, debug and register-file port bundle for urv_regfile_seq
interface urv_regfile_seq_if;
    logic [4:0]  w_rd_i;
    logic [31:0] w_rd_value_i;
    logic        w_rd_store_i;
    logic [4:0]  pipe_rs_i;
    logic        pipe_idle_i;
    logic        stall_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_we_o;
    logic [4:0]  rf_raddr_o;
    logic [31:0] rf_q_i;
    logic        init_done_o;

    modport slave (
        input  w_rd_i, w_rd_value_i, w_rd_store_i, pipe_rs_i, pipe_idle_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, rf_q_i,
        output stall_o, dbg_ack_o, dbg_rdata_o, rf_waddr_o, rf_wdata_o,
        output rf_we_o, rf_raddr_o, init_done_o
    );

    modport master (
        output w_rd_i, w_rd_value_i, w_rd_store_i, pipe_rs_i, pipe_idle_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, rf_q_i,
        input  stall_o, dbg_ack_o, dbg_rdata_o, rf_waddr_o, rf_wdata_o,
        input  rf_we_o, rf_raddr_o, init_done_o
    );
endinterface

// File: rtl/urv_regfile_seq.sv
// rtl/urv_regfile_seq.sv - register-file port sequencer: reset sweep, writeback pass-through, debug access
module urv_regfile_seq #(
    parameter logic [31:0] INIT_VALUE = 32'h0,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    urv_regfile_seq_if.slave bus
);
    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_RDWAIT = 3'd4;
    localparam logic [2:0] S_ACK    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        init_done_q, init_done_d;

    logic        pipe_wr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr;

    assign pipe_wr = bus.w_rd_store_i && (bus.w_rd_i != 5'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dbg_rdata_d = dbg_rdata_q;
        init_done_d = init_done_q;
        rf_we       = pipe_wr;
        rf_waddr    = bus.w_rd_i;
        rf_wdata    = bus.w_rd_value_i;
        rf_raddr    = bus.pipe_rs_i;
        case (state_q)
            S_INIT: begin
                // cnt starts at 1 and saturates at 31, so x0 is never swept
                rf_we    = 1'b1;
                rf_waddr = cnt_q;
                rf_wdata = INIT_VALUE;
                if (cnt_q == 5'd31) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_IDLE: begin
                if (bus.dbg_req_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.pipe_idle_i) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                rf_raddr = bus.dbg_addr_i;
                // a late pipeline writeback owns the write port; retry next cycle
                if (!pipe_wr) begin
                    if (bus.dbg_we_i) begin
                        rf_we    = (bus.dbg_addr_i != 5'd0);
                        rf_waddr = bus.dbg_addr_i;
                        rf_wdata = bus.dbg_wdata_i;
                        state_d  = S_ACK;
                    end else begin
                        state_d = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                dbg_rdata_d = (bus.dbg_addr_i == 5'd0) ? 32'h0 : bus.rf_q_i;
                state_d     = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT_EN ? S_INIT : S_IDLE;
            cnt_q       <= 5'd1;
            dbg_rdata_q <= 32'h0;
            init_done_q <= ~INIT_EN;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.stall_o     = (state_q != S_IDLE);
    assign bus.dbg_ack_o   = (state_q == S_ACK);
    assign bus.dbg_rdata_o = dbg_rdata_q;
    assign bus.rf_we_o     = rf_we;
    assign bus.rf_waddr_o  = rf_waddr;
    assign bus.rf_wdata_o  = rf_wdata;
    assign bus.rf_raddr_o  = rf_raddr;
    assign bus.init_done_o = init_done_q;
endmodule

// File: tb/tb_urv_regfile_seq.sv
// tb/tb_urv_regfile_seq.sv - bench for urv_regfile_seq with a 1-cycle RAM and a register shadow model
module tb_urv_regfile_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    urv_regfile_seq_if bus();

    urv_regfile_seq #(.INIT_VALUE(32'h0), .INIT_EN(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] ram [32];
    logic [31:0] exp_rf [32];
    int total = 0;
    int bad   = 0;

    always @(posedge clk) begin
        if (bus.rf_we_o) ram[bus.rf_waddr_o] <= bus.rf_wdata_o;
        bus.rf_q_i <= ram[bus.rf_raddr_o];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after the negedge of the first cycle with rst low.
    task automatic sweep_check();
        chk("rst_state", {bus.stall_o, bus.dbg_ack_o, bus.init_done_o, bus.dbg_rdata_o},
            {1'b1, 1'b0, 1'b0, 32'h0});
        for (int i = 1; i <= 31; i++) begin
            chk($sformatf("sweep_%0d", i),
                {bus.rf_we_o, bus.stall_o, bus.init_done_o, bus.rf_waddr_o, bus.rf_wdata_o},
                {1'b1, 1'b1, 1'b0, 5'(i), 32'h0});
            @(negedge clk); #1;
        end
        chk("sweep_done", {bus.init_done_o, bus.stall_o, bus.rf_we_o}, {1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    endtask

    task automatic pipe_wr(input logic [4:0] rd, input logic [31:0] val);
        @(negedge clk);
        bus.w_rd_i = rd; bus.w_rd_value_i = val; bus.w_rd_store_i = 1'b1;
        bus.pipe_rs_i = 5'($urandom_range(0, 31));
        #1;
        if (rd != 5'd0)
            chk("wb_pass", {bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.rf_raddr_o},
                {1'b1, rd, val, bus.pipe_rs_i});
        else
            chk("wb_x0", {bus.rf_we_o, bus.rf_raddr_o}, {1'b0, bus.pipe_rs_i});
        @(negedge clk);
        bus.w_rd_store_i = 1'b0;
        if (rd != 5'd0) exp_rf[rd] = val;
    endtask

    task automatic dbg_op(input logic we, input logic [4:0] addr, input logic [31:0] wd, input int drain);
        int lat;
        logic [31:0] exp_rd;
        exp_rd = (addr == 5'd0) ? 32'h0 : exp_rf[addr];
        @(negedge clk);
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = we; bus.dbg_addr_i = addr; bus.dbg_wdata_i = wd;
        bus.pipe_idle_i = 1'b0;
        @(negedge clk); #1;
        for (int d = 0; d < drain; d++) begin
            chk("drain_hold", {bus.stall_o, bus.dbg_ack_o}, {1'b1, 1'b0});
            @(negedge clk); #1;
        end
        chk("drain_stall", {bus.stall_o, bus.dbg_ack_o}, {1'b1, 1'b0});
        bus.pipe_idle_i = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            if (k == 1) begin
                if (we && addr != 5'd0)
                    chk("dbg_wr_port", {bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o}, {1'b1, addr, wd});
                else if (we)
                    chk("dbg_wr_x0", bus.rf_we_o, 1'b0);
                else
                    chk("dbg_rd_addr", {bus.rf_we_o, bus.rf_raddr_o}, {1'b0, addr});
            end
            if (bus.dbg_ack_o) begin
                lat = k;
                break;
            end
        end
        bus.dbg_req_i = 1'b0;
        bus.pipe_idle_i = 1'b0;
        chk(we ? "wr_latency" : "rd_latency", 64'(lat), we ? 64'd2 : 64'd3);
        if (!we) chk("dbg_rdata", bus.dbg_rdata_o, exp_rd);
        if (we && addr != 5'd0) exp_rf[addr] = wd;
        @(negedge clk); #1;
        chk("post_ack", {bus.dbg_ack_o, bus.stall_o}, {1'b0, 1'b0});
        if (!we) chk("rdata_held", bus.dbg_rdata_o, exp_rd);
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rv;
        bus.w_rd_i = 5'd0; bus.w_rd_value_i = 32'h0; bus.w_rd_store_i = 1'b0;
        bus.pipe_rs_i = 5'd0; bus.pipe_idle_i = 1'b0;
        bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 5'd0; bus.dbg_wdata_i = 32'h0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sweep_check();

        pipe_wr(5'd5, 32'hDEADBEEF);
        pipe_wr(5'd0, 32'hDEADBEEF);

        dbg_op(1'b1, 5'd7, 32'h12345678, 3);
        dbg_op(1'b0, 5'd7, 32'h0, 0);
        dbg_op(1'b0, 5'd0, 32'h0, 1);
        dbg_op(1'b0, 5'd5, 32'h0, 2);
        dbg_op(1'b1, 5'd0, 32'h55AA55AA, 0);
        dbg_op(1'b0, 5'd0, 32'h0, 0);

        // writeback to x9 collides with a debug write to x3 in ACCESS
        @(negedge clk);
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_addr_i = 5'd3; bus.dbg_wdata_i = 32'hA5A5_0003;
        @(negedge clk); #1;
        bus.pipe_idle_i = 1'b1;
        @(negedge clk);
        bus.w_rd_i = 5'd9; bus.w_rd_value_i = 32'h9999_0009; bus.w_rd_store_i = 1'b1;
        #1;
        chk("coll_pipe_first", {bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.dbg_ack_o},
            {1'b1, 5'd9, 32'h9999_0009, 1'b0});
        @(negedge clk);
        bus.w_rd_store_i = 1'b0;
        #1;
        chk("coll_dbg_next", {bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.dbg_ack_o},
            {1'b1, 5'd3, 32'hA5A5_0003, 1'b0});
        @(negedge clk); #1;
        chk("coll_ack", bus.dbg_ack_o, 1'b1);
        bus.dbg_req_i = 1'b0; bus.pipe_idle_i = 1'b0;
        @(negedge clk); #1;
        chk("coll_ack_pulse", bus.dbg_ack_o, 1'b0);
        exp_rf[9] = 32'h9999_0009;
        exp_rf[3] = 32'hA5A5_0003;
        dbg_op(1'b0, 5'd9, 32'h0, 0);
        dbg_op(1'b0, 5'd3, 32'h0, 0);

        for (int n = 0; n < 24; n++) begin
            ra = 5'($urandom_range(0, 31));
            rv = $urandom;
            case ($urandom_range(0, 2))
                0: pipe_wr(ra, rv);
                1: dbg_op(1'b1, ra, rv, int'($urandom_range(0, 3)));
                default: dbg_op(1'b0, ra, 32'h0, int'($urandom_range(0, 3)));
            endcase
        end

        // reset while waiting for read data
        dbg_op(1'b1, 5'd7, 32'hCAFEF00D, 0);
        dbg_op(1'b0, 5'd7, 32'h0, 0);
        @(negedge clk);
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 5'd7;
        @(negedge clk); #1;
        bus.pipe_idle_i = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rdwait_no_ack", {bus.dbg_ack_o, bus.stall_o}, {1'b0, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.dbg_req_i = 1'b0; bus.pipe_idle_i = 1'b0;
        #1;
        sweep_check();
        dbg_op(1'b0, 5'd7, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
